imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 110 +++++++++++
 tb/tb_imm_extend_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate decoder/extender followed by a PIPE_DEPTH-stage register pipe from D to E.
// Optional reserved-format detector is compiled in with IMM_EXTEND_ILLEGAL_DETECT_EN.
module imm_extend_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PIPE_DEPTH = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [2:0]      ImmSrcD,
  input  logic            ValidD,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [XLEN-1:0] ImmExtE,
  output logic            ValidE,
  output logic            IllegalE
);

  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic [4:0]         imm_z;
  logic [XLEN-1:0]    imm_dec;
  logic               unused_opcode;

  assign imm_i = InstrD[31:20];
  assign imm_s = {InstrD[31:25], InstrD[11:7]};
  assign imm_b = {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_u = {InstrD[31:12], 12'b0};
  assign imm_j = {InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  assign imm_z = InstrD[19:15];
  assign unused_opcode = ^InstrD[6:0];

  // Size casts of signed operands sign-extend to XLEN; imm_z is unsigned so it zero-extends.
  always_comb begin
    imm_dec = '0;
    case (ImmSrcD)
      3'b000:  imm_dec = XLEN'(imm_i);
      3'b001:  imm_dec = XLEN'(imm_s);
      3'b010:  imm_dec = XLEN'(imm_b);
      3'b011:  imm_dec = XLEN'(imm_u);
      3'b100:  imm_dec = XLEN'(imm_j);
      3'b101:  imm_dec = XLEN'(imm_z);
      default: imm_dec = '0;
    endcase
  end

  logic [PIPE_DEPTH-1:0][XLEN-1:0] data_q, data_d;
  logic [PIPE_DEPTH-1:0]           valid_q, valid_d;

  // Flush beats stall; a stalled pipe ignores the D-stage input entirely.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (FlushE) begin
      data_d  = '0;
      valid_d = '0;
    end else if (!StallE) begin
      data_d[0]  = ValidD ? imm_dec : '0;
      valid_d[0] = ValidD;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ImmExtE = data_q[PIPE_DEPTH-1];
  assign ValidE  = valid_q[PIPE_DEPTH-1];

`ifdef IMM_EXTEND_ILLEGAL_DETECT_EN
  logic [PIPE_DEPTH-1:0] illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (FlushE) begin
      illegal_d = '0;
    end else if (!StallE) begin
      illegal_d[0] = ValidD & ImmSrcD[2] & ImmSrcD[1];
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        illegal_d[i] = illegal_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= '0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalE = illegal_q[PIPE_DEPTH-1];
`else
  assign IllegalE = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32/64 at depth 1 and XLEN=32 at depth 3 share stimulus.
module tb_imm_extend_pipe;

`ifdef IMM_EXTEND_ILLEGAL_DETECT_EN
  localparam bit IllegalEn = 1'b1;
`else
  localparam bit IllegalEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [2:0]  src;
  logic        valid_d, stall, flush;

  logic [31:0] imm_a, imm_c;
  logic [63:0] imm_b;
  logic        val_a, val_b, val_c, ill_a, ill_b, ill_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .PIPE_DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .InstrD(instr), .ImmSrcD(src), .ValidD(valid_d),
    .StallE(stall), .FlushE(flush), .ImmExtE(imm_a), .ValidE(val_a), .IllegalE(ill_a)
  );

  imm_extend_pipe #(.XLEN(64), .PIPE_DEPTH(1)) u_d64 (
    .clk(clk), .reset(reset), .InstrD(instr), .ImmSrcD(src), .ValidD(valid_d),
    .StallE(stall), .FlushE(flush), .ImmExtE(imm_b), .ValidE(val_b), .IllegalE(ill_b)
  );

  imm_extend_pipe #(.XLEN(32), .PIPE_DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .InstrD(instr), .ImmSrcD(src), .ValidD(valid_d),
    .StallE(stall), .FlushE(flush), .ImmExtE(imm_c), .ValidE(val_c), .IllegalE(ill_c)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic        valid;
    logic [63:0] exp_imm;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic v);
    instr   = i;
    src     = s;
    valid_d = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Expected values are the 64-bit extension; the XLEN=32 instance sees the low half.
    vecs[0]  = '{32'hFFF00093, 3'b000, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 3'b001, 1'b1, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000CE3, 3'b010, 1'b1, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
    vecs[3]  = '{32'h123450B7, 3'b011, 1'b1, 64'h00000000_12345000, 1'b0};
    vecs[4]  = '{32'hFFDFF06F, 3'b100, 1'b1, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[5]  = '{32'h800000B7, 3'b011, 1'b1, 64'hFFFFFFFF_80000000, 1'b0};
    // zimm is InstrD[19:15]: 0x000F8073 carries 31 there, 0x0001F073 carries 3.
    vecs[6]  = '{32'h000F8073, 3'b101, 1'b1, 64'h00000000_0000001F, 1'b0};
    vecs[7]  = '{32'h0001F073, 3'b101, 1'b1, 64'h00000000_00000003, 1'b0};
    vecs[8]  = '{32'hFFF00093, 3'b000, 1'b0, 64'h0, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 3'b110, 1'b1, 64'h0, IllegalEn};
    vecs[10] = '{32'hFFFFFFFF, 3'b111, 1'b1, 64'h0, IllegalEn};

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(32'hFFF00093, 3'b000, 1'b1);
    #2;
    check("reset_imm32", {32'h0, imm_a}, 64'h0);
    check("reset_valid", {61'h0, val_a, val_b, val_c}, 64'h0);
    check("reset_imm64", imm_b, 64'h0);
    check("reset_ill", {61'h0, ill_a, ill_b, ill_c}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back vectors: each lands on the depth-1 outputs one edge later.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].instr, vecs[i].src, vecs[i].valid);
      tick();
      check($sformatf("vec%0d_imm32", i), {32'h0, imm_a}, {32'h0, vecs[i].exp_imm[31:0]});
      check($sformatf("vec%0d_imm64", i), imm_b, vecs[i].exp_imm);
      check($sformatf("vec%0d_valid", i), {62'h0, val_a, val_b}, {62'h0, vecs[i].valid, vecs[i].valid});
      check($sformatf("vec%0d_ill", i), {62'h0, ill_a, ill_b}, {62'h0, vecs[i].exp_ill, vecs[i].exp_ill});
    end

    // Stall on the depth-3 pipe: A, B issued, two stall cycles with a decoy, then C.
    drive(32'h0, 3'b000, 1'b0);
    do_reset();
    drive(32'h00100093, 3'b000, 1'b1);
    tick();
    check("stall_e1_valid", {63'h0, val_c}, 64'h0);
    drive(32'h00200093, 3'b000, 1'b1);
    tick();
    check("stall_e2_valid", {63'h0, val_c}, 64'h0);
    drive(32'h7FF00093, 3'b000, 1'b1);
    stall = 1'b1;
    tick();
    check("stall_e3_valid", {63'h0, val_c}, 64'h0);
    tick();
    check("stall_e4_valid", {63'h0, val_c}, 64'h0);
    stall = 1'b0;
    drive(32'hFFE00093, 3'b000, 1'b1);
    tick();
    check("stall_a_imm", {32'h0, imm_c}, 64'h1);
    check("stall_a_valid", {63'h0, val_c}, 64'h1);
    drive(32'h0, 3'b000, 1'b0);
    tick();
    check("stall_b_imm", {32'h0, imm_c}, 64'h2);
    tick();
    check("stall_c_imm", {32'h0, imm_c}, 64'hFFFFFFFE);
    check("stall_c_valid", {63'h0, val_c}, 64'h1);
    tick();
    check("stall_drain_valid", {63'h0, val_c}, 64'h0);
    check("stall_drain_imm", {32'h0, imm_c}, 64'h0);

    // Flush together with stall while two entries are in flight.
    drive(32'h00100093, 3'b000, 1'b1);
    tick();
    drive(32'h00200093, 3'b110, 1'b1);
    tick();
    drive(32'h7FF00093, 3'b000, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("flush_valid", {62'h0, val_c, val_a}, 64'h0);
    check("flush_imm", {imm_c, imm_a}, 64'h0);
    stall = 1'b0;
    flush = 1'b0;
    drive(32'h0, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("flush_after%0d_valid", k), {62'h0, val_c, ill_c}, 64'h0);
      check($sformatf("flush_after%0d_imm", k), {32'h0, imm_c}, 64'h0);
    end

    // Asynchronous reset between edges while the depth-1 output is live.
    drive(32'h123450B7, 3'b011, 1'b1);
    tick();
    check("pre_reset_imm", {32'h0, imm_a}, 64'h12345000);
    check("pre_reset_valid", {63'h0, val_a}, 64'h1);
    drive(32'h0, 3'b000, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_reset_imm", {imm_a, 32'h0}, 64'h0);
    check("async_reset_imm64", imm_b, 64'h0);
    check("async_reset_valid", {61'h0, val_a, val_b, val_c}, 64'h0);
    #1 reset = 1'b0;

    // First valid after reset release reaches the depth-3 output three edges later.
    tick();
    drive(32'hFE20AE23, 3'b001, 1'b1);
    tick();
    check("post_reset_d1_imm", {32'h0, imm_a}, 64'hFFFFFFFC);
    check("post_reset_d3_e1", {63'h0, val_c}, 64'h0);
    drive(32'h0, 3'b000, 1'b0);
    tick();
    check("post_reset_d3_e2", {63'h0, val_c}, 64'h0);
    tick();
    check("post_reset_d3_imm", {32'h0, imm_c}, 64'hFFFFFFFC);
    check("post_reset_d3_valid", {63'h0, val_c}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
